// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads each 16-bit instruction as two byte reads (high byte first)
// and hands it to decode over valid/ready. Define FETCH_PREFETCH_EN for a one-entry prefetch buffer.
module instr_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            o_mem_req,
    output logic [PC_W:0]   o_mem_addr,
    input  logic [7:0]      i_mem_rdata,
    input  logic            i_mem_ack,
    output logic [15:0]     o_instr,
    output logic [PC_W-1:0] o_instr_pc,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    input  logic            i_redirect_valid,
    input  logic [PC_W-1:0] i_redirect_pc
);
    localparam logic [1:0] F_HI = 2'd0;
    localparam logic [1:0] F_LO = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_mem_req;
    logic [PC_W:0]   r_mem_addr;
    logic [7:0]      r_hi;
    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_instr_pc;
    logic            r_instr_valid;

    logic            w_hs;
    logic            w_word_done;
    logic [PC_W-1:0] w_pc_inc;
    logic [15:0]     w_word;

    assign w_hs        = r_instr_valid & i_instr_ready;
    assign w_word_done = (r_state == F_LO) & r_mem_req & i_mem_ack;
    assign w_pc_inc    = r_pc + 1'b1;
    assign w_word      = {r_hi, i_mem_rdata};

`ifdef FETCH_PREFETCH_EN
    // r_pc is the next word to fetch; decoded words live in the output register, then the buffer.
    logic [15:0]     r_buf;
    logic [PC_W-1:0] r_buf_pc;
    logic            r_buf_valid;
    logic [1:0]      w_occ_next;

    assign w_occ_next = 2'(r_instr_valid) + 2'(r_buf_valid) - 2'(w_hs) + 2'(w_word_done);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr       <= '0;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_buf         <= '0;
            r_buf_pc      <= '0;
            r_buf_valid   <= 1'b0;
        end else if (i_redirect_valid) begin
            r_instr_valid <= 1'b0;
            r_buf_valid   <= 1'b0;
        end else if (w_hs && r_buf_valid) begin
            r_instr     <= r_buf;
            r_instr_pc  <= r_buf_pc;
            r_buf_valid <= w_word_done;
            if (w_word_done) begin
                r_buf    <= w_word;
                r_buf_pc <= r_pc;
            end
        end else if (w_word_done && r_instr_valid && !w_hs) begin
            r_buf       <= w_word;
            r_buf_pc    <= r_pc;
            r_buf_valid <= 1'b1;
        end else if (w_word_done) begin
            r_instr       <= w_word;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
        end else if (w_hs) begin
            r_instr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= F_HI;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_hi       <= '0;
        end else if (i_redirect_valid) begin
            r_state   <= F_HI;
            r_pc      <= i_redirect_pc;
            r_mem_req <= 1'b0;
        end else begin
            case (r_state)
                F_HI: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_pc, 1'b0};
                    end else if (i_mem_ack) begin
                        r_hi       <= i_mem_rdata;
                        r_mem_addr <= {r_pc, 1'b1};
                        r_state    <= F_LO;
                    end
                end
                F_LO: begin
                    if (w_word_done) begin
                        r_pc <= w_pc_inc;
                        // Both slots occupied after this edge: park the memory port.
                        if (w_occ_next == 2'd2) begin
                            r_mem_req <= 1'b0;
                            r_state   <= HOLD;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {w_pc_inc, 1'b0};
                            r_state    <= F_HI;
                        end
                    end
                end
                HOLD: begin
                    if (w_hs) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_pc, 1'b0};
                        r_state    <= F_HI;
                    end
                end
                default: r_state <= F_HI;
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= F_HI;
            r_pc          <= RESET_PC;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_hi          <= '0;
            r_instr       <= '0;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
        end else if (i_redirect_valid) begin
            // Redirect beats a same-cycle handshake; any byte acked now is dropped.
            r_state       <= F_HI;
            r_pc          <= i_redirect_pc;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                F_HI: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_pc, 1'b0};
                    end else if (i_mem_ack) begin
                        r_hi       <= i_mem_rdata;
                        r_mem_addr <= {r_pc, 1'b1};
                        r_state    <= F_LO;
                    end
                end
                F_LO: begin
                    if (w_word_done) begin
                        r_instr       <= w_word;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    // Launch the next high-byte request on the handshake edge to keep 3 cycles/instr.
                    if (w_hs) begin
                        r_instr_valid <= 1'b0;
                        r_pc          <= w_pc_inc;
                        r_mem_req     <= 1'b1;
                        r_mem_addr    <= {w_pc_inc, 1'b0};
                        r_state       <= F_HI;
                    end
                end
                default: r_state <= F_HI;
            endcase
        end
    end
`endif

    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: byte-memory responder, cycle model + handshake scoreboard, directed tests.
module tb_instr_fetch_unit;
    localparam int PC_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            o_mem_req;
    logic [PC_W:0]   o_mem_addr;
    logic [7:0]      i_mem_rdata = 8'h00;
    logic            i_mem_ack = 1'b0;
    logic [15:0]     o_instr;
    logic [PC_W-1:0] o_instr_pc;
    logic            o_instr_valid;
    logic            i_instr_ready = 1'b0;
    logic            i_redirect_valid = 1'b0;
    logic [PC_W-1:0] i_redirect_pc = '0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .o_instr(o_instr), .o_instr_pc(o_instr_pc), .o_instr_valid(o_instr_valid),
        .i_instr_ready(i_instr_ready),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory image: addresses 0/1 hold 'h12/'h34, everything else a fixed hash of the address.
    function automatic logic [7:0] mem_byte(input logic [PC_W:0] a);
        if (a == 0) return 8'h12;
        if (a == 1) return 8'h34;
        return a[7:0] ^ a[16:9] ^ 8'h5A;
    endfunction

    function automatic logic [15:0] mem_word(input logic [PC_W-1:0] pc);
        return {mem_byte({pc, 1'b0}), mem_byte({pc, 1'b1})};
    endfunction

    // Memory responder: acks each held request after ack_delay wait cycles.
    int ack_delay = 0;
    bit spurious  = 1'b0;
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (o_mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mem_byte(o_mem_addr);
                    wait_cnt    = 0;
                end else begin
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = 8'hEE;
                    wait_cnt++;
                end
            end else begin
                i_mem_ack   = spurious;
                i_mem_rdata = 8'hEE;
                wait_cnt    = 0;
            end
        end
    end

    // Compare process: checks outputs against the model, then advances the model with this cycle's inputs.
    initial begin
        bit              m_live;
        logic [PC_W-1:0] m_pc, m_ipc, sb_pc;
        logic            m_req, m_valid, m_lo;
        logic [15:0]     m_instr;
        m_live = 0; m_pc = '0; m_ipc = '0; sb_pc = '0;
        m_req = 0; m_valid = 0; m_lo = 0; m_instr = '0;
        forever begin
            @(negedge clk);
            if (m_live) begin
`ifndef FETCH_PREFETCH_EN
                check("model.req", 32'(o_mem_req), 32'(m_req));
                if (m_req) check("model.addr", 32'(o_mem_addr), 32'({m_pc, m_lo}));
                check("model.valid", 32'(o_instr_valid), 32'(m_valid));
                if (m_valid) begin
                    check("model.instr", 32'(o_instr), 32'(m_instr));
                    check("model.ipc", 32'(o_instr_pc), 32'(m_ipc));
                end
`endif
                if (rst_n && o_instr_valid && i_instr_ready) begin
                    check("sb.ipc", 32'(o_instr_pc), 32'(sb_pc));
                    check("sb.instr", 32'(o_instr), 32'(mem_word(sb_pc)));
                    sb_pc = sb_pc + 1'b1;
                end
            end
            if (!rst_n) begin
                m_live = 1; m_pc = '0; m_ipc = '0; sb_pc = '0;
                m_req = 0; m_valid = 0; m_lo = 0; m_instr = '0;
            end else if (i_redirect_valid) begin
                sb_pc = i_redirect_pc;
                m_pc = i_redirect_pc; m_valid = 0; m_req = 0; m_lo = 0;
            end else if (m_valid) begin
                if (i_instr_ready) begin
                    m_valid = 0; m_pc = m_pc + 1'b1; m_req = 1; m_lo = 0;
                end
            end else if (!m_req) begin
                m_req = 1;
            end else if (i_mem_ack) begin
                if (m_lo) begin
                    m_valid = 1; m_ipc = m_pc; m_instr = mem_word(m_pc); m_req = 0; m_lo = 0;
                end else begin
                    m_lo = 1;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset two edges, check reset values, release; the next edge is "cycle 1".
    task automatic do_reset();
        rst_n = 1'b0;
        i_redirect_valid = 1'b0;
        cyc(2);
        check("rst.req", 32'(o_mem_req), 32'h0);
        check("rst.addr", 32'(o_mem_addr), 32'h0);
        check("rst.valid", 32'(o_instr_valid), 32'h0);
        check("rst.instr", 32'(o_instr), 32'h0);
        check("rst.ipc", 32'(o_instr_pc), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
`ifndef FETCH_PREFETCH_EN
        // 1: immediate acks, best-case timing
        ack_delay = 0; i_instr_ready = 1'b1;
        do_reset();
        cyc(1); check("t1.req_hi", 32'(o_mem_req), 32'h1); check("t1.addr0", 32'(o_mem_addr), 32'h0);
        cyc(1); check("t1.addr1", 32'(o_mem_addr), 32'h1);
        cyc(1); check("t1.valid", 32'(o_instr_valid), 32'h1);
        check("t1.instr", 32'(o_instr), 32'h1234); check("t1.ipc", 32'(o_instr_pc), 32'h0);
        cyc(1); check("t1.addr2", 32'(o_mem_addr), 32'h2); check("t1.valid_lo", 32'(o_instr_valid), 32'h0);
        cyc(1); check("t1.addr3", 32'(o_mem_addr), 32'h3);

        // 2: four wait cycles per byte (reset lands mid-fetch)
        ack_delay = 4;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cyc(1); check("t2.req_hold", 32'(o_mem_req), 32'h1); check("t2.addr_hold", 32'(o_mem_addr), 32'h0);
        end
        cyc(1); check("t2.addr_lo", 32'(o_mem_addr), 32'h1);
        cyc(4); check("t2.not_yet", 32'(o_instr_valid), 32'h0); check("t2.addr_lo_hold", 32'(o_mem_addr), 32'h1);
        cyc(1); check("t2.valid", 32'(o_instr_valid), 32'h1); check("t2.req_off", 32'(o_mem_req), 32'h0);

        // 3: decode stall; stray acks while idle are ignored
        ack_delay = 0; i_instr_ready = 1'b0;
        do_reset();
        cyc(3); spurious = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("t3.valid", 32'(o_instr_valid), 32'h1); check("t3.instr", 32'(o_instr), 32'h1234);
            check("t3.ipc", 32'(o_instr_pc), 32'h0); check("t3.req", 32'(o_mem_req), 32'h0);
        end
        spurious = 1'b0; i_instr_ready = 1'b1;
        cyc(1); check("t3.hs_valid", 32'(o_instr_valid), 32'h0); check("t3.next_addr", 32'(o_mem_addr), 32'h2);

        // 4: redirect during the low-byte read with a same-cycle ack
        do_reset();
        cyc(2); i_redirect_valid = 1'b1; i_redirect_pc = 16'h0040;
        cyc(1); i_redirect_valid = 1'b0;
        check("t4.req_gap", 32'(o_mem_req), 32'h0); check("t4.valid", 32'(o_instr_valid), 32'h0);
        cyc(1); check("t4.req", 32'(o_mem_req), 32'h1); check("t4.addr", 32'(o_mem_addr), 32'h80);
        cyc(1); check("t4.addr_lo", 32'(o_mem_addr), 32'h81);
        cyc(1); check("t4.ipc", 32'(o_instr_pc), 32'h40); check("t4.instr", 32'(o_instr), 32'hDADB);

        // 5: redirect to the top of the PC space (wins over the pending handshake), then wrap
        i_redirect_valid = 1'b1; i_redirect_pc = 16'hFFFF;
        cyc(1); i_redirect_valid = 1'b0;
        check("t5.valid_off", 32'(o_instr_valid), 32'h0);
        cyc(1); check("t5.addr_hi", 32'(o_mem_addr), 32'h1FFFE);
        cyc(1); check("t5.addr_lo", 32'(o_mem_addr), 32'h1FFFF);
        cyc(1); check("t5.ipc", 32'(o_instr_pc), 32'hFFFF); check("t5.instr", 32'(o_instr), 32'h5B5A);
        cyc(1); check("t5.wrap_addr", 32'(o_mem_addr), 32'h0);
        cyc(2); check("t5.wrap_ipc", 32'(o_instr_pc), 32'h0); check("t5.wrap_instr", 32'(o_instr), 32'h1234);

        // Back-to-back redirects: the second target is fetched
        i_redirect_valid = 1'b1; i_redirect_pc = 16'h0010;
        cyc(1); i_redirect_pc = 16'h0020;
        cyc(1); i_redirect_valid = 1'b0;
        check("bb.req_gap", 32'(o_mem_req), 32'h0);
        cyc(1); check("bb.addr", 32'(o_mem_addr), 32'h40);
        cyc(2); check("bb.ipc", 32'(o_instr_pc), 32'h20);

        // Mixed stalls and waits, left to the model and scoreboard
        ack_delay = 1;
        for (int i = 0; i < 40; i++) begin
            i_instr_ready = (i % 3) != 0;
            cyc(1);
        end
`else
        // 6: prefetch fills both slots, zero-bubble promotion, then redirect flush
        ack_delay = 0; i_instr_ready = 1'b0;
        do_reset();
        cyc(12);
        check("t6.full_valid", 32'(o_instr_valid), 32'h1); check("t6.full_req", 32'(o_mem_req), 32'h0);
        check("t6.ipc0", 32'(o_instr_pc), 32'h0);
        i_instr_ready = 1'b1;
        cyc(1); check("t6.no_bubble", 32'(o_instr_valid), 32'h1); check("t6.ipc1", 32'(o_instr_pc), 32'h1);
        for (int i = 0; i < 40; i++) begin
            i_instr_ready = (i % 3) != 0;
            cyc(1);
        end
        i_redirect_valid = 1'b1; i_redirect_pc = 16'h0100;
        cyc(1); i_redirect_valid = 1'b0;
        check("t6.flush", 32'(o_instr_valid), 32'h0);
        i_instr_ready = 1'b1;
        cyc(4); check("t6.redir_ipc", 32'(o_instr_pc), 32'h100);
        cyc(10);
`endif
        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
